// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// clocks out one odd-parity byte on device clock falls and checks the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [IW-1:0] inh_cnt_q;
    logic [WW-1:0] wdog_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          clk_low_q;
    logic          dat_low_q;

    logic          clk_s1_q;
    logic          clk_s2_q;
    logic          clk_prev_q;
    logic          dat_s1_q;
    logic          dat_s2_q;
    logic          fall_q;

    // Synchronizers idle high so a reset never fabricates a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
            fall_q     <= clk_prev_q & ~clk_s2_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            wdog_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        shift_q   <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        clk_low_q <= 1'b1;
                        dat_low_q <= 1'b0;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                        dat_low_q <= 1'b1;
                        state_q   <= S_REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + IW'(1);
                    end
                end
                S_REQ: begin
                    clk_low_q <= 1'b0;
                    wdog_q    <= WW'(TIMEOUT_CYCLES);
                    bit_cnt_q <= '0;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    if (fall_q) begin
                        dat_low_q <= ~shift_q[bit_cnt_q];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        wdog_q    <= WW'(TIMEOUT_CYCLES);
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end else if (wdog_q == '0) begin
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        clk_low_q <= 1'b0;
                        dat_low_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q - WW'(1);
                    end
                end
                S_ACK: begin
                    // The device pulls data low before the 11th fall to acknowledge.
                    if (fall_q) begin
                        if (!dat_s2_q) begin
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            busy_q    <= 1'b0;
                            err_q     <= 1'b1;
                            clk_low_q <= 1'b0;
                            dat_low_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end else if (wdog_q == '0) begin
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        clk_low_q <= 1'b0;
                        dat_low_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q - WW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_s2_q && dat_s2_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (wdog_q == '0) begin
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        clk_low_q <= 1'b0;
                        dat_low_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q - WW'(1);
                    end
                end
                default: begin
                    busy_q    <= 1'b0;
                    clk_low_q <= 1'b0;
                    dat_low_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_busy           = busy_q;
    assign tx_done           = done_q;
    assign tx_error          = err_q;
    assign ps2_clk_drive_low = clk_low_q;
    assign ps2_dat_drive_low = dat_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device drives the shared
// open-drain lines and each observation is checked with an immediate assertion.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 400;
    localparam int H   = 10;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       dev_clk_low;
    logic       dev_dat_low;

    int n_assert;
    int n_fail;
    int done_cnt;
    int err_cnt;
    int both_cnt;

    // Wired-AND of the two open-drain drivers on each line.
    assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .tx_data          (tx_data),
        .tx_start         (tx_start),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .tx_error         (tx_error),
        .ps2_clk_in       (ps2_clk_in),
        .ps2_dat_in       (ps2_dat_in),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_dat_drive_low(ps2_dat_drive_low)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // Device side of one frame: 10 clocks sampling on rising edges, then the ack clock.
    task automatic dev_frame(input logic ack, output logic [9:0] got, output logic start_bit);
        start_bit = ps2_dat_in;
        got = '0;
        repeat (H) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            got[i] = ps2_dat_in;
            repeat (H) @(negedge clock);
        end
        if (ack) dev_dat_low = 1'b1;
        repeat (H) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clock);
        dev_dat_low = 1'b0;
    endtask

    task automatic send_body(input logic [9:0] exp, input string tag);
        logic [9:0] got;
        logic       sb;
        int         n;
        check({tag, "_busy_on"}, 32'(tx_busy), 32'd1);
        n = 0;
        while (ps2_clk_drive_low && !ps2_dat_drive_low && n < 4 * INH) begin
            n++;
            @(negedge clock);
        end
        check({tag, "_inhibit_len"}, 32'(n), 32'(INH));
        check({tag, "_req"}, {30'd0, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd3);
        @(negedge clock);
        check({tag, "_release"}, {30'd0, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd1);
        dev_frame(1'b1, got, sb);
        check({tag, "_start_bit"}, 32'(sb), 32'd0);
        check({tag, "_frame"}, 32'(got), 32'(exp));
        check({tag, "_busy_frame"}, 32'(tx_busy), 32'd1);
        n = 0;
        while (!tx_done && n < 50) begin
            n++;
            @(negedge clock);
        end
        check({tag, "_done_seen"}, 32'(tx_done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(tx_busy), 32'd0);
        check({tag, "_lines_at_done"}, {30'd0, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);
    endtask

    initial begin
        logic [9:0] got;
        logic       sb;
        int         d0;
        int         e0;
        int         k;

        n_assert    = 0;
        n_fail      = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        both_cnt    = 0;
        reset       = 1'b1;
        tx_data     = 8'h00;
        tx_start    = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);

        // 0xED set-LEDs: data LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1
        d0 = done_cnt; e0 = err_cnt;
        start_cmd(8'hED);
        send_body(10'b11_1110_1101, "ed");
        @(negedge clock);
        check("ed_done_once", 32'(done_cnt - d0), 32'd1);
        check("ed_no_error", 32'(err_cnt - e0), 32'd0);

        // Parity corners; 0x01 is started in the cycle right after 0x00's done
        d0 = done_cnt;
        start_cmd(8'h00);
        send_body(10'b11_0000_0000, "p00");
        tx_data  = 8'h01;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        send_body(10'b10_0000_0001, "p01");
        start_cmd(8'hFF);
        send_body(10'b11_1111_1111, "pff");
        @(negedge clock);
        check("parity_done_cnt", 32'(done_cnt - d0), 32'd3);

        // NACK: device leaves data high on the 11th clock
        d0 = done_cnt; e0 = err_cnt;
        start_cmd(8'hED);
        k = 0;
        while (ps2_clk_drive_low && k < 4 * INH) begin
            k++;
            @(negedge clock);
        end
        dev_frame(1'b0, got, sb);
        check("nack_frame", 32'(got), 32'(10'b11_1110_1101));
        check("nack_error_once", 32'(err_cnt - e0), 32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_idle", {29'd0, tx_busy, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);

        // Timeout: no device clock after the request
        e0 = err_cnt;
        start_cmd(8'hF4);
        k = 0;
        while (!tx_error && k < INH + TO + 100) begin
            k++;
            @(negedge clock);
        end
        check("timeout_seen", 32'(tx_error), 32'd1);
        check("timeout_not_early", 32'(k >= INH + TO - 1), 32'd1);
        check("timeout_not_late", 32'(k <= INH + TO + 3), 32'd1);
        check("timeout_idle", {29'd0, tx_busy, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);
        @(negedge clock);
        check("timeout_error_once", 32'(err_cnt - e0), 32'd1);

        // 0x55 requested during the SEND of 0xF4 must be dropped
        d0 = done_cnt;
        start_cmd(8'hF4);
        k = 0;
        while (ps2_clk_drive_low && k < 4 * INH) begin
            k++;
            @(negedge clock);
        end
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_frame(1'b1, got, sb);
        check("busy_start_frame", 32'(got), 32'(10'b10_1111_0100));
        repeat (20) @(negedge clock);
        check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start_no_requeue", {30'd0, tx_busy, ps2_clk_drive_low}, 32'd0);

        // Reset after the 4th device clock fall aborts silently
        d0 = done_cnt; e0 = err_cnt;
        start_cmd(8'hED);
        k = 0;
        while (ps2_clk_drive_low && k < 4 * INH) begin
            k++;
            @(negedge clock);
        end
        repeat (H) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clock);
        end
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clock);
        check("rst_mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);
        reset       = 1'b0;
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_mid_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
        start_cmd(8'hFF);
        send_body(10'b11_1111_1111, "after_rst");
        @(negedge clock);
        check("after_rst_done_once", 32'(done_cnt - d0), 32'd1);

        check("never_both_pulses", 32'(both_cnt), 32'd0);
        check("total_done", 32'(done_cnt), 32'd6);
        check("total_error", 32'(err_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
